// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl
// Sequences a WIDTH-bit Johnson (twisted-ring) counter for a programmed number
// of steps in either direction. Supports pause, stop and preset-load, and
// reports busy/done status plus a decoded phase index for multi-phase enable
// generation downstream.
module johnson_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int PH_W  = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic             pause,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] jc_out,
    output logic [PH_W-1:0]  phase,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] jc;
    logic [CNT_W-1:0] remaining;
    logic             run_dir;

    // A legal Johnson code is a thermometer pattern anchored at bit 0 or at the
    // MSB. A value anchored at bit 0 has no set bit above a clear bit, so
    // v & (v+1) clears to zero; the MSB-anchored case is the same test on ~v.
    // All-zeros and all-ones pass both forms.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] inv;
        logic             low_therm;
        logic             high_therm;
        inv        = ~v;
        low_therm  = ((v & (v + WIDTH'(1))) == '0);
        high_therm = ((inv & (inv + WIDTH'(1))) == '0);
        return low_therm || high_therm;
    endfunction

    // Number of ones in the register. It never exceeds WIDTH, so it fits in PH_W bits.
    function automatic logic [PH_W-1:0] ones_of(input logic [WIDTH-1:0] v);
        logic [PH_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + PH_W'(v[i]);
        end
        return cnt;
    endfunction

    // Decode the ring position. While the MSB is clear, the ring is filling with
    // ones, and the phase equals the popcount. Once the MSB is set, the ring is
    // draining, and the phase is 2*WIDTH - popcount. That value is formed as
    // (2*WIDTH-1) - popcount + 1 so every intermediate result stays inside PH_W
    // bits, even when 2*WIDTH is not a power of two.
    function automatic logic [PH_W-1:0] phase_of(input logic [WIDTH-1:0] v);
        logic [PH_W-1:0] cnt;
        cnt = ones_of(v);
        if (!v[WIDTH-1]) begin
            return cnt;
        end
        return (PH_W'(2*WIDTH-1) - cnt) + PH_W'(1);
    endfunction

    // Forward shift: the inverted MSB enters at bit 0.
    function automatic logic [WIDTH-1:0] shift_fwd(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ~v[WIDTH-1]};
    endfunction

    // Reverse shift: the inverted bit 0 enters at the MSB.
    function automatic logic [WIDTH-1:0] shift_rev(input logic [WIDTH-1:0] v);
        return {~v[0], v[WIDTH-1:1]};
    endfunction

    // Sequencer FSM, counter register, step counter and status outputs.
    // busy and done are registered alongside the state, so each always equals
    // the decode of the state it accompanies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            jc        <= '0;
            remaining <= '0;
            run_dir   <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (load) begin
                        // Load wins over start; an illegal preset parks the
                        // ring at zero and latches the error until reset.
                        if (is_legal(load_val)) begin
                            jc <= load_val;
                        end else begin
                            jc  <= '0;
                            err <= 1'b1;
                        end
                    end else if (start) begin
                        if (steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= steps;
                            run_dir   <= dir;
                            state     <= RUN;
                            busy      <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pause) begin
                        state <= HOLD;
                    end else begin
                        jc        <= run_dir ? shift_rev(jc) : shift_fwd(jc);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Leaving HOLD spends one edge without shifting; the
                    // next shift happens on the following edge in RUN.
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign jc_out = jc;
    assign phase  = phase_of(jc);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: a directed vector table plus
// hand-written multi-cycle sequences (wrap, pause, stop, async reset).
module tb_johnson_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] steps;
    logic       dir;
    logic       pause;
    logic       stop;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] jc_out;
    logic [3:0] phase;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk;
    int n_pass;

    johnson_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .steps    (steps),
        .dir      (dir),
        .pause    (pause),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .jc_out   (jc_out),
        .phase    (phase),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] steps;
        logic       dir;
        logic       pause;
        logic       stop;
        logic       load;
        logic [7:0] load_val;
        logic [7:0] e_jc;
        logic [3:0] e_ph;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic st, input logic [7:0] sp, input logic dr,
                                input logic pa, input logic so, input logic ld,
                                input logic [7:0] lv, input logic [7:0] ejc,
                                input logic [3:0] eph, input logic eb,
                                input logic ed, input logic ee);
        vec_t v;
        v.start = st; v.steps = sp; v.dir = dr; v.pause = pa; v.stop = so;
        v.load = ld; v.load_val = lv; v.e_jc = ejc; v.e_ph = eph;
        v.e_busy = eb; v.e_done = ed; v.e_err = ee;
        return v;
    endfunction

    // Closed-form forward-ring value after k shifts from zero.
    function automatic logic [7:0] fwd_exp(input int k);
        logic [15:0] t;
        if (k <= 8) t = (16'd1 << k) - 16'd1;
        else        t = 16'h00FF << (k - 8);
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ejc, input logic [3:0] eph,
                           input logic eb, input logic ed, input logic ee);
        chk({tag, ".jc"},    32'(jc_out), 32'(ejc));
        chk({tag, ".phase"}, 32'(phase),  32'(eph));
        chk({tag, ".busy"},  32'(busy),   32'(eb));
        chk({tag, ".done"},  32'(done),   32'(ed));
        chk({tag, ".err"},   32'(err),    32'(ee));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; steps = 0; dir = 0; pause = 0; stop = 0; load = 0; load_val = 0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        idle_inputs();

        // Reset held high
        #1;
        @(posedge clk);
        #1;
        chk_all("reset_hold", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc();
        chk_all("reset_idle", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Forward wrap, 16 steps, with a stray start pulse mid-run
        start = 1; steps = 8'd16; dir = 0;
        cyc();
        idle_inputs();
        chk_all("wrap_e0", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin start = 1; steps = 8'd2; end
            cyc();
            idle_inputs();
            chk_all($sformatf("wrap_e%0d", k), fwd_exp(k), 4'(k % 16),
                    (k < 16), (k == 16), 1'b0);
        end
        cyc();
        chk_all("wrap_after", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Pause after two shifts for four cycles; ten shifts in total
        start = 1; steps = 8'd10;
        cyc();
        idle_inputs();
        chk_all("pause_e0", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            cyc();
            chk_all($sformatf("pause_s%0d", k), fwd_exp(k), 4'(k), 1'b1, 1'b0, 1'b0);
        end
        pause = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_all($sformatf("pause_hold%0d", k), 8'h03, 4'd2, 1'b1, 1'b0, 1'b0);
        end
        pause = 0;
        cyc();
        chk_all("pause_resume", 8'h03, 4'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 3; k <= 10; k++) begin
            cyc();
            chk_all($sformatf("pause_s%0d", k), fwd_exp(k), 4'(k), (k < 10), (k == 10), 1'b0);
        end
        cyc();
        chk_all("pause_after", 8'hFC, 4'd10, 1'b0, 1'b0, 1'b0);

        // Stop after five shifts, with a start in the same cycle
        load = 1; load_val = 8'h00;
        cyc();
        idle_inputs();
        chk_all("stop_load0", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1; steps = 8'd10;
        cyc();
        idle_inputs();
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk_all($sformatf("stop_s%0d", k), fwd_exp(k), 4'(k), 1'b1, 1'b0, 1'b0);
        end
        stop = 1; start = 1; steps = 8'd3;
        cyc();
        idle_inputs();
        chk_all("stop_edge", 8'h1F, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_all("stop_after1", 8'h1F, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_all("stop_after2", 8'h1F, 4'd5, 1'b0, 1'b0, 1'b0);

        // Directed vector table: reverse run, loads, zero-step start, ignored inputs
        //          st steps  dr pa sp ld lv     e_jc   ph  b  d  e
        tbl[0]  = mk(0, 8'd0, 0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 0, 0);
        tbl[1]  = mk(1, 8'd3, 1, 0, 0, 0, 8'h00, 8'h00, 0,  1, 0, 0);
        tbl[2]  = mk(0, 8'd0, 0, 0, 0, 0, 8'h00, 8'h80, 15, 1, 0, 0);
        tbl[3]  = mk(0, 8'd0, 0, 0, 0, 0, 8'h00, 8'hC0, 14, 1, 0, 0);
        tbl[4]  = mk(0, 8'd0, 0, 0, 0, 0, 8'h00, 8'hE0, 13, 0, 1, 0);
        tbl[5]  = mk(0, 8'd0, 0, 0, 0, 0, 8'h00, 8'hE0, 13, 0, 0, 0);
        tbl[6]  = mk(0, 8'd0, 0, 0, 0, 1, 8'h0F, 8'h0F, 4,  0, 0, 0);
        tbl[7]  = mk(1, 8'd0, 0, 0, 0, 0, 8'h00, 8'h0F, 4,  0, 1, 0);
        tbl[8]  = mk(0, 8'd0, 0, 0, 0, 0, 8'h00, 8'h0F, 4,  0, 0, 0);
        tbl[9]  = mk(1, 8'd2, 0, 0, 0, 1, 8'h03, 8'h03, 2,  0, 0, 0);
        tbl[10] = mk(1, 8'd2, 0, 0, 0, 0, 8'h00, 8'h03, 2,  1, 0, 0);
        tbl[11] = mk(0, 8'd0, 0, 0, 0, 1, 8'hFF, 8'h07, 3,  1, 0, 0);
        tbl[12] = mk(1, 8'd5, 0, 0, 0, 0, 8'h00, 8'h0F, 4,  0, 1, 0);
        tbl[13] = mk(1, 8'd5, 0, 0, 0, 1, 8'h00, 8'h0F, 4,  0, 0, 0);
        tbl[14] = mk(0, 8'd0, 0, 0, 0, 1, 8'h05, 8'h00, 0,  0, 0, 1);
        tbl[15] = mk(0, 8'd0, 0, 0, 0, 1, 8'hF0, 8'hF0, 12, 0, 0, 1);
        tbl[16] = mk(0, 8'd0, 0, 0, 0, 1, 8'hFE, 8'hFE, 9,  0, 0, 1);
        for (int i = 0; i < 17; i++) begin
            start = tbl[i].start; steps = tbl[i].steps; dir = tbl[i].dir;
            pause = tbl[i].pause; stop = tbl[i].stop; load = tbl[i].load;
            load_val = tbl[i].load_val;
            cyc();
            chk_all($sformatf("vec%0d", i), tbl[i].e_jc, tbl[i].e_ph,
                    tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
        end
        idle_inputs();

        // Asynchronous reset mid-run clears everything, including sticky err
        start = 1; steps = 8'd10;
        cyc();
        idle_inputs();
        cyc();
        chk("arst_s1.jc", 32'(jc_out), 32'h0FC);
        cyc();
        chk("arst_s2.jc", 32'(jc_out), 32'h0F8);
        cyc();
        chk_all("arst_s3", 8'hF0, 4'd12, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst_async", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        chk_all("arst_after", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
Controller that sequences an internal WIDTH-bit Johnson (twisted-ring) counter.
- Runs the counter for a programmed number of steps in either direction, with pause, stop and preset-load.
- Reports busy/done status and a decoded phase index.
- Feeds multi-phase enable generation downstream of the existing Johnson counter datapath.

Parameters:
WIDTH, 8, Johnson register width; ring has 2*WIDTH states.
CNT_W, 8, width of step-count input and internal remaining-step counter.
PH_W, $clog2(2*WIDTH), width of phase output (4 for defaults).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a run; sampled only in IDLE.
steps  input  CNT_W  number of shifts for the run; latched on accepted start.
dir  input  1  0 = forward, 1 = reverse; latched on accepted start.
pause  input  1  level; holds the counter while high during a run.
stop  input  1  aborts the run.
load  input  1  preset the counter; honoured only in IDLE.
load_val  input  WIDTH  preset value.
jc_out  output  WIDTH  Johnson register value.
phase  output  PH_W  decoded state index 0..2*WIDTH-1.
busy  output  1  high in RUN or HOLD.
done  output  1  one-cycle pulse at run completion.
err  output  1  sticky flag for an illegal preset.

Behaviour:
- Reset (async, immediate, including mid-run):
  - jc_out=0, state=IDLE, remaining=0, busy=0, done=0, err=0.
  - phase=0, since it follows jc_out.
- States: IDLE, RUN, HOLD, DONE. busy=(RUN|HOLD); done=(state==DONE). Both are Moore outputs.
- Forward shift: jc <= {jc[W-2:0], ~jc[W-1]}. Reverse shift: jc <= {~jc[0], jc[W-1:1]}.
- IDLE:
  - load takes priority over start in the same cycle.
  - load with load_val a legal Johnson code: jc <= load_val.
  - load with an illegal code: jc <= 0 and err <= 1. err stays set until rst.
  - Legal codes are the 2*WIDTH thermometer patterns: ones contiguous from bit0 upward, or contiguous from bit W-1 downward, including all-0 and all-1.
  - start with steps!=0: latch steps into remaining, latch dir, go to RUN. No shift on this edge.
  - start with steps==0: go directly to DONE (done pulse, no shift).
- RUN:
  - Priority is stop > pause > shift.
  - stop=1: go to IDLE, no shift, jc holds, no done pulse.
  - pause=1: go to HOLD, no shift.
  - Otherwise shift once and decrement remaining. If remaining was 1, go to DONE.
- HOLD:
  - stop=1: go to IDLE.
  - pause=0: go to RUN. No shift on that edge; shifting resumes on the next edge.
  - Otherwise stay in HOLD.
- DONE: one cycle, then unconditionally IDLE. start, load and stop are ignored in DONE.
- start and load are ignored while busy. steps and dir changes mid-run have no effect.
- Timing, with start accepted at edge E0 and no pause:
  - Shifts occur on edges E1..EN.
  - busy is high from E0 to EN.
  - done is high from EN to EN+1.
  - State is IDLE at EN+1; a new start may be accepted at EN+1.
- Wrap-around is natural: 2*WIDTH forward shifts return jc to its start value. remaining counts down, CNT_W bits, no overflow.
- phase is combinational from jc_out:
  - jc[W-1]==0: phase = popcount(jc).
  - Otherwise: phase = 2*WIDTH - popcount(jc).
  - Examples: 00000011 -> 2, 11111111 -> 8, 11111110 -> 9, 10000000 -> 15.

Test Plan:
1. Hold rst high, then pulse rst high mid-run -> all outputs 0 immediately (asynchronous, no clock edge needed); state IDLE.
2. Forward wrap: from reset, start with steps=16, dir=0 -> jc goes 00000001, 00000011 … 11111111, 11111110 … 10000000, 00000000 on E1..E16; phase counts 1..15 then 0; done high exactly one cycle after E16; busy low thereafter.
3. Reverse run: from 0, start with steps=3, dir=1 -> jc goes 10000000, 11000000, 11100000; phase 15, 14, 13; done pulse; jc holds 11100000 in IDLE.
4. Pause/stop: steps=10, pause for 4 cycles after the 2nd shift -> jc frozen at 00000011 with busy=1, total shifts still 10. A second run with stop asserted after 5 shifts -> IDLE, jc=00011111, no done pulse; a start in the same cycle as stop is ignored.
5. Load:
   - load 00001111 in IDLE -> jc=00001111, phase 4, err=0.
   - load 00000101 -> jc=00000000, err=1, sticky until rst.
   - load asserted during RUN -> ignored.
6. Edge starts: start with steps=0 -> done on the next cycle, jc unchanged, busy never high. start pulsed during RUN -> no effect on the remaining count.
